// File: rtl/lsp_pkg.sv
// Shared types for the load/store pipe: access width codes, MEM FSM states and
// the lane helpers used by address generation and alignment.
package lsp_pkg;

    typedef enum logic [1:0] {
        MW_B = 2'd0,
        MW_H = 2'd1,
        MW_W = 2'd2,
        MW_D = 2'd3
    } mw_e;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_REQ  = 2'd1,
        M_WAIT = 2'd2
    } lsp_state_e;

    function automatic logic [7:0] base_mask(input mw_e w);
        case (w)
            MW_B:    return 8'h01;
            MW_H:    return 8'h03;
            MW_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic misaligned(input mw_e w, input logic [2:0] off);
        case (w)
            MW_H:    return off[0];
            MW_W:    return |off[1:0];
            MW_D:    return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsp_if.sv
// Issue-side bundle, writeback and D-cache port of the load/store pipe.
// LSP_MISALIGN_TRAP_EN adds the misalignment report signals.
interface lsp_if #(parameter int DM_ADDR_W = 64);
    logic [63:0]          ix_lsp_pc;
    logic [4:0]           ix_lsp_dst;
    logic                 ix_lsp_wb_en;
    logic [63:0]          ix_lsp_base;
    logic [11:0]          ix_lsp_offset;
    logic [63:0]          ix_lsp_source;
    logic                 ix_lsp_mem_sign;
    logic [1:0]           ix_lsp_mem_width;
    logic                 ix_lsp_valid;
    logic                 ix_lsp_ready;
    logic                 lsp_ix_mem_busy;
    logic                 lsp_ix_mem_wb_en;
    logic [4:0]           lsp_ix_mem_dst;
    logic                 lsp_wb_valid;
    logic                 lsp_wb_wb_en;
    logic [4:0]           lsp_wb_dst;
    logic [63:0]          lsp_wb_result;
    logic                 dm_req_valid;
    logic                 dm_req_ready;
    logic                 dm_req_wen;
    logic [DM_ADDR_W-1:0] dm_req_addr;
    logic [63:0]          dm_req_wdata;
    logic [7:0]           dm_req_wmask;
    logic                 dm_resp_valid;
    logic [63:0]          dm_resp_rdata;
`ifdef LSP_MISALIGN_TRAP_EN
    logic                 lsp_misalign_valid;
    logic [63:0]          lsp_misalign_pc;
    logic [63:0]          lsp_misalign_addr;

    modport slave (
        input  ix_lsp_pc, ix_lsp_dst, ix_lsp_wb_en, ix_lsp_base, ix_lsp_offset, ix_lsp_source,
               ix_lsp_mem_sign, ix_lsp_mem_width, ix_lsp_valid, dm_req_ready, dm_resp_valid, dm_resp_rdata,
        output ix_lsp_ready, lsp_ix_mem_busy, lsp_ix_mem_wb_en, lsp_ix_mem_dst, lsp_wb_valid, lsp_wb_wb_en,
               lsp_wb_dst, lsp_wb_result, dm_req_valid, dm_req_wen, dm_req_addr, dm_req_wdata, dm_req_wmask,
               lsp_misalign_valid, lsp_misalign_pc, lsp_misalign_addr
    );
    modport master (
        output ix_lsp_pc, ix_lsp_dst, ix_lsp_wb_en, ix_lsp_base, ix_lsp_offset, ix_lsp_source,
               ix_lsp_mem_sign, ix_lsp_mem_width, ix_lsp_valid, dm_req_ready, dm_resp_valid, dm_resp_rdata,
        input  ix_lsp_ready, lsp_ix_mem_busy, lsp_ix_mem_wb_en, lsp_ix_mem_dst, lsp_wb_valid, lsp_wb_wb_en,
               lsp_wb_dst, lsp_wb_result, dm_req_valid, dm_req_wen, dm_req_addr, dm_req_wdata, dm_req_wmask,
               lsp_misalign_valid, lsp_misalign_pc, lsp_misalign_addr
    );
`else
    modport slave (
        input  ix_lsp_pc, ix_lsp_dst, ix_lsp_wb_en, ix_lsp_base, ix_lsp_offset, ix_lsp_source,
               ix_lsp_mem_sign, ix_lsp_mem_width, ix_lsp_valid, dm_req_ready, dm_resp_valid, dm_resp_rdata,
        output ix_lsp_ready, lsp_ix_mem_busy, lsp_ix_mem_wb_en, lsp_ix_mem_dst, lsp_wb_valid, lsp_wb_wb_en,
               lsp_wb_dst, lsp_wb_result, dm_req_valid, dm_req_wen, dm_req_addr, dm_req_wdata, dm_req_wmask
    );
    modport master (
        output ix_lsp_pc, ix_lsp_dst, ix_lsp_wb_en, ix_lsp_base, ix_lsp_offset, ix_lsp_source,
               ix_lsp_mem_sign, ix_lsp_mem_width, ix_lsp_valid, dm_req_ready, dm_resp_valid, dm_resp_rdata,
        input  ix_lsp_ready, lsp_ix_mem_busy, lsp_ix_mem_wb_en, lsp_ix_mem_dst, lsp_wb_valid, lsp_wb_wb_en,
               lsp_wb_dst, lsp_wb_result, dm_req_valid, dm_req_wen, dm_req_addr, dm_req_wdata, dm_req_wmask
    );
`endif
endinterface

// File: rtl/lsp_lane_align.sv
// Byte-lane steering: store data/mask shift into the 8-byte word, and load
// extract plus sign/zero extension out of it.
module lsp_lane_align
    import lsp_pkg::*;
(
    input  logic [2:0]  i_st_off,
    input  mw_e         i_st_width,
    input  logic [63:0] i_st_data,
    output logic [63:0] o_st_wdata,
    output logic [7:0]  o_st_wmask,
    input  logic [2:0]  i_ld_off,
    input  mw_e         i_ld_width,
    input  logic        i_ld_sign,
    input  logic [63:0] i_ld_word,
    output logic [63:0] o_ld_data
);

    logic [63:0] w_ld_sh;

    // Lanes pushed past byte 7 fall off the top of both data and mask.
    assign o_st_wdata = i_st_data << {i_st_off, 3'b000};
    assign o_st_wmask = base_mask(i_st_width) << i_st_off;
    assign w_ld_sh    = i_ld_word >> {i_ld_off, 3'b000};

    always_comb begin
        o_ld_data = w_ld_sh;
        case (i_ld_width)
            MW_B:    o_ld_data = {{56{i_ld_sign & w_ld_sh[7]}},  w_ld_sh[7:0]};
            MW_H:    o_ld_data = {{48{i_ld_sign & w_ld_sh[15]}}, w_ld_sh[15:0]};
            MW_W:    o_ld_data = {{32{i_ld_sign & w_ld_sh[31]}}, w_ld_sh[31:0]};
            default: o_ld_data = w_ld_sh;
        endcase
    end

endmodule

// File: rtl/lsp.sv
// Load/store pipe: combinational AG, one-entry MEM stage with D-cache handshake,
// registered WB. LSP_MISALIGN_TRAP_EN enables misaligned-access reporting.
module lsp
    import lsp_pkg::*;
#(
    parameter int DM_ADDR_W = 64
) (
    input logic  clk,
    input logic  rst,
    lsp_if.slave bus
);

    lsp_state_e  r_state;
    logic        r_ld;
    logic        r_wb_valid;
    logic        r_wb_wb_en;
    logic [63:0] r_ea;
    logic [63:0] r_wdata;
    logic [7:0]  r_wmask;
    logic [4:0]  r_dst;
    mw_e         r_width;
    logic        r_sign;
    logic [4:0]  r_wb_dst;
    logic [63:0] r_wb_result;

    logic [63:0] w_ea;
    logic [63:0] w_addr_al;
    logic [63:0] w_st_wdata;
    logic [7:0]  w_st_wmask;
    logic [63:0] w_ld_data;
    logic        w_done;
    logic        w_accept;
    logic        w_mem_mis;

    assign w_ea      = bus.ix_lsp_base + {{52{bus.ix_lsp_offset[11]}}, bus.ix_lsp_offset};
    assign w_addr_al = {r_ea[63:3], 3'b000};
    assign w_accept  = bus.ix_lsp_valid & bus.ix_lsp_ready;

`ifdef LSP_MISALIGN_TRAP_EN
    logic        r_mis;
    logic        r_mis_valid;
    logic [63:0] r_pc;
    logic [63:0] r_mis_pc;
    logic [63:0] r_mis_addr;

    assign w_mem_mis              = r_mis;
    assign bus.lsp_misalign_valid = r_mis_valid;
    assign bus.lsp_misalign_pc    = r_mis_pc;
    assign bus.lsp_misalign_addr  = r_mis_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_mis_valid <= 1'b0;
        else     r_mis_valid <= w_done & r_mis;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mis <= misaligned(mw_e'(bus.ix_lsp_mem_width), w_ea[2:0]);
            r_pc  <= bus.ix_lsp_pc;
        end
        if (w_done) begin
            r_mis_pc   <= r_pc;
            r_mis_addr <= r_ea;
        end
    end
`else
    assign w_mem_mis = 1'b0;
`endif

    lsp_lane_align u_align (
        .i_st_off   (w_ea[2:0]),
        .i_st_width (mw_e'(bus.ix_lsp_mem_width)),
        .i_st_data  (bus.ix_lsp_source),
        .o_st_wdata (w_st_wdata),
        .o_st_wmask (w_st_wmask),
        .i_ld_off   (r_ea[2:0]),
        .i_ld_width (r_width),
        .i_ld_sign  (r_sign),
        .i_ld_word  (bus.dm_resp_rdata),
        .o_ld_data  (w_ld_data)
    );

    // A response arriving with the request handshake finishes the load from M_REQ.
    always_comb begin
        w_done = 1'b0;
        case (r_state)
            M_REQ:   w_done = w_mem_mis | (bus.dm_req_ready & (~r_ld | bus.dm_resp_valid));
            M_WAIT:  w_done = bus.dm_resp_valid;
            default: w_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= M_IDLE;
            r_ld       <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_wb_en <= 1'b0;
        end else begin
            r_wb_valid <= w_done;
            if (w_done)   r_wb_wb_en <= r_ld & ~w_mem_mis;
            if (w_accept) r_ld       <= bus.ix_lsp_wb_en;
            case (r_state)
                M_IDLE: if (w_accept) r_state <= M_REQ;
                M_REQ: begin
                    if (w_done)                r_state <= w_accept ? M_REQ : M_IDLE;
                    else if (bus.dm_req_ready) r_state <= M_WAIT;
                end
                M_WAIT: if (w_done) r_state <= w_accept ? M_REQ : M_IDLE;
                default: r_state <= M_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_ea    <= w_ea;
            r_wdata <= w_st_wdata;
            r_wmask <= w_st_wmask;
            r_dst   <= bus.ix_lsp_dst;
            r_width <= mw_e'(bus.ix_lsp_mem_width);
            r_sign  <= bus.ix_lsp_mem_sign;
        end
        if (w_done) begin
            r_wb_dst    <= r_dst;
            r_wb_result <= w_ld_data;
        end
    end

    assign bus.ix_lsp_ready     = ~rst & ((r_state == M_IDLE) | w_done);
    assign bus.lsp_ix_mem_busy  = (r_state != M_IDLE);
    assign bus.lsp_ix_mem_wb_en = (r_state != M_IDLE) & r_ld;
    assign bus.lsp_ix_mem_dst   = r_dst;
    assign bus.lsp_wb_valid     = r_wb_valid;
    assign bus.lsp_wb_wb_en     = r_wb_wb_en;
    assign bus.lsp_wb_dst       = r_wb_dst;
    assign bus.lsp_wb_result    = r_wb_result;
    assign bus.dm_req_valid     = (r_state == M_REQ) & ~w_mem_mis;
    assign bus.dm_req_wen       = ~r_ld;
    assign bus.dm_req_addr      = w_addr_al[DM_ADDR_W-1:0];
    assign bus.dm_req_wdata     = r_wdata;
    assign bus.dm_req_wmask     = r_wmask;

endmodule
